// File: rtl/clk_div_sel.sv
// ---------------------------------------------------------------------------
// clk_div_sel
//
// Free-running binary divider with a selectable, glitch-free output tap.
// Bit k of the divider counter is a divide-by-2^(k+1) square wave; one of
// those bits (the active tap) is re-registered onto clk_out. Changing the
// tap goes through a small handshake so that no runt high or low phase is
// ever emitted while moving from the old tap to the new one.
//
// Parameters
//   WIDTH   width of the divider counter (number of available taps)
//   SEL_W   width of the tap-select input, 2^SEL_W >= WIDTH
//
// Ports
//   clk      in   system clock, all state changes on its rising edge
//   rst_n    in   synchronous active-low reset
//   en       in   count enable; 0 freezes the counter and clk_out
//   sel      in   requested tap (k selects divide-by-2^(k+1))
//   load     in   one-cycle request to switch to tap sel
//   div_cnt  out  free-running counter value
//   clk_out  out  registered divided level from the active tap
//   tick     out  one-cycle pulse in the cycle clk_out rises
//   busy     out  high while a tap switch is in flight
//   sel_err  out  one-cycle pulse when a load asks for a non-existent tap
// ---------------------------------------------------------------------------
module clk_div_sel #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [WIDTH-1:0] div_cnt,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             sel_err
);

  // Internal tap indices only need enough bits to address WIDTH taps;
  // sel is range-checked before it is narrowed.
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cur_sel;
  logic [IDX_W-1:0] cur_sel_nxt;
  logic [IDX_W-1:0] pend_sel;
  logic [IDX_W-1:0] pend_sel_nxt;

  logic             sel_ok;
  logic             cur_bit;
  logic             pend_bit;
  logic             clk_out_nxt;
  logic             tick_nxt;
  logic             sel_err_nxt;

  // Request is only honoured for taps that actually exist.
  assign sel_ok   = (32'(sel) < 32'(WIDTH));
  assign cur_bit  = div_cnt[cur_sel];
  assign pend_bit = div_cnt[pend_sel];

  // -------------------------------------------------------------------------
  // Divider counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= div_cnt + WIDTH'(1);
    end
  end

  // -------------------------------------------------------------------------
  // FSM state register (also owns the tap-select registers)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_sel  <= '0;
      pend_sel <= '0;
    end else begin
      state    <= state_nxt;
      cur_sel  <= cur_sel_nxt;
      pend_sel <= pend_sel_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  //   ARM waits for the old tap to be low so its current high phase is
  //   never cut short; HOLD keeps the output low until the new tap is also
  //   low, so the first new high phase starts on a true rising edge of the
  //   new tap. Transitions use the counter as-is, so with en=0 they see the
  //   frozen value.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    cur_sel_nxt  = cur_sel;
    pend_sel_nxt = pend_sel;
    case (state)
      IDLE: begin
        if (load && sel_ok) begin
          pend_sel_nxt = sel[IDX_W-1:0];
          state_nxt    = ARM;
        end
      end
      ARM: begin
        if (!cur_bit) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!pend_bit) begin
          cur_sel_nxt = pend_sel;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM output logic
  //   clk_out only moves while counting, which also keeps tick quiet when
  //   the counter is frozen.
  // -------------------------------------------------------------------------
  always_comb begin
    clk_out_nxt = clk_out;
    sel_err_nxt = 1'b0;
    if (en) begin
      case (state)
        IDLE, ARM: clk_out_nxt = cur_bit;
        HOLD:      clk_out_nxt = 1'b0;
        default:   clk_out_nxt = 1'b0;
      endcase
    end
    if ((state == IDLE) && load && !sel_ok) begin
      sel_err_nxt = 1'b1;
    end
    tick_nxt = clk_out_nxt & ~clk_out;
  end

  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_out <= 1'b0;
      tick    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      clk_out <= clk_out_nxt;
      tick    <= tick_nxt;
      sel_err <= sel_err_nxt;
    end
  end

endmodule

// File: doc/clk_div_sel.md
CLK_DIV_SEL -- requirements
Module: clk_div_sel

Interface
REQ-001: Parameter WIDTH, default 32: width of the free-running divider counter.
REQ-002: Parameter SEL_W, default 6: width of the tap-select input; must satisfy 2^SEL_W >= WIDTH.
REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: en  input  1  count enable; 0 freezes the counter.
REQ-006: sel  input  SEL_W  requested tap index (0 = divide-by-2, k = divide-by-2^(k+1)).
REQ-007: load  input  1  single-cycle request to switch the output to tap sel.
REQ-008: div_cnt  output  WIDTH  free-running counter value; bit k is a divide-by-2^(k+1) square wave.
REQ-009: clk_out  output  1  registered, glitch-free divided level from the active tap.
REQ-010: tick  output  1  one-cycle pulse marking each rising edge of clk_out.
REQ-011: busy  output  1  high while a tap switch is in progress.
REQ-012: sel_err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-013: div_cnt SHALL increment by 1 modulo 2^WIDTH on each clk when en=1, and SHALL hold when en=0; all-ones wraps to 0.
REQ-014: The block SHALL keep an active tap cur_sel; in IDLE, clk_out(t+1) = div_cnt(t)[cur_sel(t)] (one-cycle latency).
REQ-015: tick SHALL be registered and high for exactly the cycle in which clk_out changes from 0 to 1.
REQ-016: The FSM SHALL have three states: IDLE, ARM, HOLD.
REQ-017: IDLE with load=1 and sel<WIDTH: latch sel into pend_sel, set busy=1, go to ARM.
REQ-018: IDLE with load=1 and sel>=WIDTH: ignore the request, pulse sel_err for one cycle, stay in IDLE, leave cur_sel unchanged.
REQ-019: ARM: clk_out follows the old tap as in IDLE; when div_cnt[cur_sel]==0, go to HOLD.
REQ-020: HOLD: clk_out forced to 0; when div_cnt[pend_sel]==0, set cur_sel<=pend_sel, clear busy, go to IDLE.
REQ-021: The switch sequence SHALL never produce a clk_out high or low phase shorter than the shorter of the old and new tap half-periods.
REQ-022: load while busy=1 SHALL be ignored without sel_err; pend_sel is not overwritten.
REQ-023: load with sel==cur_sel SHALL run the full IDLE->ARM->HOLD->IDLE sequence.
REQ-024: en=0 SHALL freeze div_cnt and hold clk_out; FSM transitions evaluate on the frozen counter value.
REQ-025: tick SHALL stay 0 while en=0, because clk_out does not change.

Reset
REQ-026: With rst_n=0 at a clk edge, the block SHALL set div_cnt=0, cur_sel=0, pend_sel=0, state=IDLE, clk_out=0, tick=0, busy=0, sel_err=0.
REQ-027: Reset during ARM or HOLD SHALL abandon the pending switch; the active tap after reset is 0.
REQ-028: Reset SHALL take priority over load and en in the same cycle.

Verification
REQ-029: Reset, then en=1, no load -> clk_out toggles every cycle (tap 0), and tick pulses every 2 cycles starting 2 cycles after the first increment.
REQ-030: load with sel=2 from tap 0 -> busy=1 for the switch; clk_out then shows period 8 (4 high, 4 low); no phase shorter than 1 cycle appears during the switch.
REQ-031: load with sel=40 (WIDTH=32) -> sel_err pulses 1 cycle; busy stays 0; cur_sel is unchanged.
REQ-032: load with sel=3, then load with sel=1 while busy=1 -> the second load is ignored; the final tap is 3 (period 16).
REQ-033: en=0 for 10 cycles mid-run -> div_cnt and clk_out are constant and tick=0; counting resumes from the held value.
REQ-034: Preload div_cnt near 2^WIDTH-1 via long run or force, with tap WIDTH-1 -> wrap to 0 drives clk_out low exactly at the wrap; a rst_n=0 pulse during HOLD returns all outputs to reset values the next cycle.
